// File: rtl/shared_alu_update_seq.sv
// Time-multiplexed update of a'=b+c, d'=a-D_OFF, b'=d+B_OFF, c'=c+C_INC using one adder.
// Old values are snapshotted at start; all four results commit together on one edge.
module shared_alu_update_seq #(
  parameter int WIDTH = 32,
  parameter int D_OFF = 3,
  parameter int B_OFF = 10,
  parameter int C_INC = 1,
  parameter int RST_A = 30,
  parameter int RST_B = 20,
  parameter int RST_C = 15,
  parameter int RST_D = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             init_load,
  input  logic [WIDTH-1:0] init_a,
  input  logic [WIDTH-1:0] init_b,
  input  logic [WIDTH-1:0] init_c,
  input  logic [WIDTH-1:0] init_d,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [15:0]      step_count
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OP_A   = 3'd1,
    OP_D   = 3'd2,
    OP_B   = 3'd3,
    OP_C   = 3'd4,
    COMMIT = 3'd5
  } state_t;

  localparam logic [WIDTH-1:0] L_NEG_D = WIDTH'(0) - WIDTH'(D_OFF);
  localparam logic [WIDTH-1:0] L_B_OFF = WIDTH'(B_OFF);
  localparam logic [WIDTH-1:0] L_C_INC = WIDTH'(C_INC);

  state_t           r_state;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d;
  logic [WIDTH-1:0] r_sa, r_sb, r_sc, r_sd;
  logic [WIDTH-1:0] r_ta, r_tb, r_tc, r_td;
  logic             r_busy;
  logic             r_done;
  logic [15:0]      r_step_count;

  logic [WIDTH-1:0] w_opx;
  logic [WIDTH-1:0] w_opy;
  logic [WIDTH-1:0] w_sum;

  // Operand selection for the single shared adder; subtraction uses the negated constant.
  always_comb begin
    w_opx = '0;
    w_opy = '0;
    case (r_state)
      OP_A: begin w_opx = r_sb; w_opy = r_sc;    end
      OP_D: begin w_opx = r_sa; w_opy = L_NEG_D; end
      OP_B: begin w_opx = r_sd; w_opy = L_B_OFF; end
      OP_C: begin w_opx = r_sc; w_opy = L_C_INC; end
      default: begin w_opx = '0; w_opy = '0; end
    endcase
  end

  assign w_sum = w_opx + w_opy;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_a          <= WIDTH'(RST_A);
      r_b          <= WIDTH'(RST_B);
      r_c          <= WIDTH'(RST_C);
      r_d          <= WIDTH'(RST_D);
      r_sa         <= '0;
      r_sb         <= '0;
      r_sc         <= '0;
      r_sd         <= '0;
      r_ta         <= '0;
      r_tb         <= '0;
      r_tc         <= '0;
      r_td         <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_step_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (init_load) begin
            r_a <= init_a;
            r_b <= init_b;
            r_c <= init_c;
            r_d <= init_d;
          end else if (start) begin
            r_sa    <= r_a;
            r_sb    <= r_b;
            r_sc    <= r_c;
            r_sd    <= r_d;
            r_state <= OP_A;
            r_busy  <= 1'b1;
          end
        end
        OP_A: begin
          r_ta    <= w_sum;
          r_state <= OP_D;
        end
        OP_D: begin
          r_td    <= w_sum;
          r_state <= OP_B;
        end
        OP_B: begin
          r_tb    <= w_sum;
          r_state <= OP_C;
        end
        OP_C: begin
          r_tc    <= w_sum;
          r_state <= COMMIT;
        end
        COMMIT: begin
          r_a          <= r_ta;
          r_b          <= r_tb;
          r_c          <= r_tc;
          r_d          <= r_td;
          r_done       <= 1'b1;
          r_step_count <= r_step_count + 16'd1;
          r_state      <= IDLE;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign a          = r_a;
  assign b          = r_b;
  assign c          = r_c;
  assign d          = r_d;
  assign busy       = r_busy;
  assign done       = r_done;
  assign step_count = r_step_count;

endmodule
